// File: rtl/mmio_port_responder.sv
// Memory-mapped responder beside DataMemory: output port, synchronized input port with
// sticky rising-edge flags, and a compare-match cycle timer, all behind a 32-byte window.
module mmio_port_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h1001_0100,
    parameter int          PORT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [31:0]           Address,
    input  logic [31:0]           WriteData,
    input  logic [PORT_WIDTH-1:0] PortIn,
    output logic [31:0]           ReadData,
    output logic                  Hit,
    output logic [31:0]           PortOut,
    output logic                  Irq
);

    localparam logic [2:0] OFF_PORT_OUT  = 3'd0;
    localparam logic [2:0] OFF_PORT_IN   = 3'd1;
    localparam logic [2:0] OFF_EDGE_STAT = 3'd2;
    localparam logic [2:0] OFF_EDGE_MASK = 3'd3;
    localparam logic [2:0] OFF_TMR_CNT   = 3'd4;
    localparam logic [2:0] OFF_TMR_CMP   = 3'd5;
    localparam logic [2:0] OFF_TMR_CTRL  = 3'd6;
    localparam logic [2:0] OFF_TMR_STAT  = 3'd7;

    logic [31:0]           portOut_q,  portOut_d;
    logic [PORT_WIDTH-1:0] sync1_q,    sync1_d;
    logic [PORT_WIDTH-1:0] sync2_q,    sync2_d;
    logic [PORT_WIDTH-1:0] prev_q,     prev_d;
    logic [PORT_WIDTH-1:0] edgeStat_q, edgeStat_d;
    logic [PORT_WIDTH-1:0] edgeMask_q, edgeMask_d;
    logic [31:0]           tmrCnt_q,   tmrCnt_d;
    logic [31:0]           tmrCmp_q,   tmrCmp_d;
    logic                  tmrEn_q,    tmrEn_d;
    logic                  tmrMie_q,   tmrMie_d;
    logic                  match_q,    match_d;

    logic [2:0]            offset;
    logic                  hitAddr;
    logic                  wrEn;
    logic                  rdEn;
    logic [PORT_WIDTH-1:0] rise;
    logic                  matchNow;
    logic [31:0]           portInExt;
    logic [31:0]           edgeStatExt;
    logic [31:0]           edgeMaskExt;

    assign hitAddr  = (Address[31:5] == BASE_ADDR[31:5]) && (Address[1:0] == 2'b00);
    assign offset   = Address[4:2];
    assign wrEn     = MemWrite & hitAddr;
    assign rdEn     = MemRead & hitAddr;
    assign Hit      = hitAddr;
    assign rise     = sync2_q & ~prev_q;
    assign matchNow = tmrEn_q && (tmrCnt_q == tmrCmp_q);

    always_comb begin
        portInExt                     = '0;
        edgeStatExt                   = '0;
        edgeMaskExt                   = '0;
        portInExt[PORT_WIDTH-1:0]     = sync2_q;
        edgeStatExt[PORT_WIDTH-1:0]   = edgeStat_q;
        edgeMaskExt[PORT_WIDTH-1:0]   = edgeMask_q;
    end

    // Reads see the current register contents, so a same-cycle store returns the old value.
    always_comb begin
        ReadData = '0;
        if (rdEn) begin
            case (offset)
                OFF_PORT_OUT:  ReadData = portOut_q;
                OFF_PORT_IN:   ReadData = portInExt;
                OFF_EDGE_STAT: ReadData = edgeStatExt;
                OFF_EDGE_MASK: ReadData = edgeMaskExt;
                OFF_TMR_CNT:   ReadData = tmrCnt_q;
                OFF_TMR_CMP:   ReadData = tmrCmp_q;
                OFF_TMR_CTRL:  ReadData = {30'd0, tmrMie_q, tmrEn_q};
                OFF_TMR_STAT:  ReadData = {31'd0, match_q};
                default:       ReadData = '0;
            endcase
        end
    end

    always_comb begin
        portOut_d  = portOut_q;
        sync1_d    = PortIn;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        edgeStat_d = edgeStat_q;
        edgeMask_d = edgeMask_q;
        tmrCnt_d   = tmrCnt_q;
        tmrCmp_d   = tmrCmp_q;
        tmrEn_d    = tmrEn_q;
        tmrMie_d   = tmrMie_q;
        match_d    = match_q;

        if (tmrEn_q) begin
            tmrCnt_d = matchNow ? 32'd0 : tmrCnt_q + 32'd1;
        end

        if (wrEn) begin
            case (offset)
                OFF_PORT_OUT:  portOut_d  = WriteData;
                OFF_EDGE_STAT: edgeStat_d = edgeStat_q & ~WriteData[PORT_WIDTH-1:0];
                OFF_EDGE_MASK: edgeMask_d = WriteData[PORT_WIDTH-1:0];
                OFF_TMR_CNT:   tmrCnt_d   = WriteData;
                OFF_TMR_CMP:   tmrCmp_d   = WriteData;
                OFF_TMR_CTRL: begin
                    tmrEn_d  = WriteData[0];
                    tmrMie_d = WriteData[1];
                end
                OFF_TMR_STAT:  match_d    = match_q & ~WriteData[0];
                default: ;
            endcase
        end

        // Hardware set events take priority over a same-cycle software clear.
        edgeStat_d = edgeStat_d | rise;
        if (matchNow) begin
            match_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            portOut_q  <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            edgeStat_q <= '0;
            edgeMask_q <= '0;
            tmrCnt_q   <= '0;
            tmrCmp_q   <= '0;
            tmrEn_q    <= 1'b0;
            tmrMie_q   <= 1'b0;
            match_q    <= 1'b0;
        end else begin
            portOut_q  <= portOut_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            edgeStat_q <= edgeStat_d;
            edgeMask_q <= edgeMask_d;
            tmrCnt_q   <= tmrCnt_d;
            tmrCmp_q   <= tmrCmp_d;
            tmrEn_q    <= tmrEn_d;
            tmrMie_q   <= tmrMie_d;
            match_q    <= match_d;
        end
    end

    assign PortOut = portOut_q;
    assign Irq     = (|(edgeStat_q & edgeMask_q)) | (match_q & tmrMie_q);

endmodule

// File: tb/tb_mmio_port_responder.sv
// Directed bench for mmio_port_responder: a register-map model is compared against the
// DUT every cycle, and hand-computed literals pin both the DUT and the model.
module tb_mmio_port_responder;

    localparam logic [31:0] BASE = 32'h1001_0100;

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [7:0]  PortIn;
    logic [31:0] ReadData;
    logic        Hit;
    logic [31:0] PortOut;
    logic        Irq;

    int compared   = 0;
    int mismatched = 0;
    bit cmpOn      = 0;

    mmio_port_responder #(.BASE_ADDR(BASE), .PORT_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .Address(Address), .WriteData(WriteData), .PortIn(PortIn),
        .ReadData(ReadData), .Hit(Hit), .PortOut(PortOut), .Irq(Irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: r[] mirrors the register map by word offset (r[1] unused, PORT_IN comes
    // from the synchronizer history), s1/s2/prev are the PortIn sample history.
    typedef struct packed {
        logic [7:0][31:0] r;
        logic [7:0]       s1;
        logic [7:0]       s2;
        logic [7:0]       prev;
    } mstate_t;

    mstate_t m = '0;

    function automatic bit addrHit(logic [31:0] a);
        return (a[31:5] == BASE[31:5]) && (a[1:0] == 2'b00);
    endfunction

    function automatic logic [31:0] modelRead(mstate_t s, logic [2:0] off);
        if (off == 3'd1) return {24'd0, s.s2};
        return s.r[off];
    endfunction

    function automatic logic modelIrq(mstate_t s);
        return (|(s.r[2] & s.r[3])) | (s.r[7][0] & s.r[6][1]);
    endfunction

    function automatic mstate_t nextState(mstate_t s, logic wr, logic [31:0] a,
                                          logic [31:0] wd, logic [7:0] pin);
        mstate_t    n        = s;
        logic [7:0] rise     = s.s2 & ~s.prev;
        logic       matchNow = s.r[6][0] && (s.r[4] == s.r[5]);
        logic [2:0] off      = a[4:2];
        n.s1   = pin;
        n.s2   = s.s1;
        n.prev = s.s2;
        if (s.r[6][0]) n.r[4] = matchNow ? 32'd0 : s.r[4] + 32'd1;
        if (wr && addrHit(a)) begin
            case (off)
                3'd0: n.r[0] = wd;
                3'd2: n.r[2] = s.r[2] & ~{24'd0, wd[7:0]};
                3'd3: n.r[3] = {24'd0, wd[7:0]};
                3'd4: n.r[4] = wd;
                3'd5: n.r[5] = wd;
                3'd6: n.r[6] = {30'd0, wd[1:0]};
                3'd7: n.r[7] = s.r[7] & ~{31'd0, wd[0]};
                default: ;
            endcase
        end
        n.r[2] = n.r[2] | {24'd0, rise};
        if (matchNow) n.r[7] = 32'd1;
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) m <= '0;
        else        m <= nextState(m, MemWrite, Address, WriteData, PortIn);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every negative edge, all outputs are checked against the model.
    always @(negedge clk) begin
        if (cmpOn) begin
            checkOutput("cyc Hit", {31'd0, Hit}, {31'd0, addrHit(Address)});
            checkOutput("cyc ReadData", ReadData,
                        (MemRead && addrHit(Address)) ? modelRead(m, Address[4:2]) : 32'd0);
            checkOutput("cyc PortOut", PortOut, m.r[0]);
            checkOutput("cyc Irq", {31'd0, Irq}, {31'd0, modelIrq(m)});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [4:0] off, input logic [31:0] data);
        MemWrite  = 1'b1;
        Address   = BASE + {27'd0, off};
        WriteData = data;
        step();
        MemWrite  = 1'b0;
    endtask

    task automatic readReg(input string name, input logic [4:0] off, input logic [31:0] exp);
        MemRead = 1'b1;
        Address = BASE + {27'd0, off};
        #1;
        checkOutput(name, ReadData, exp);
        checkOutput({name, " model"}, modelRead(m, off[4:2]), exp);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset = 1'b1; MemRead = 0; MemWrite = 0; Address = '0; WriteData = '0; PortIn = '0;
        #2 reset = 1'b0;
        cmpOn = 1;
        #1;
        checkOutput("reset PortOut", PortOut, 32'd0);
        checkOutput("reset Irq", {31'd0, Irq}, 32'd0);
        step(); step();
        reset = 1'b1;
        step();

        // Output port store and load back.
        MemWrite = 1'b1; Address = BASE; WriteData = 32'hA5A5_0F0F;
        #1;
        checkOutput("store Hit", {31'd0, Hit}, 32'd1);
        step();
        MemWrite = 1'b0;
        checkOutput("PortOut after store", PortOut, 32'hA5A5_0F0F);
        readReg("load PORT_OUT", 5'h00, 32'hA5A5_0F0F);

        // Input synchronizer and edge capture.
        applyStimulus(5'h0C, 32'h0000_0001);
        PortIn = 8'h81;
        step();
        step();
        readReg("PORT_IN after 2 edges", 5'h04, 32'h81);
        readReg("EDGE_STAT not yet", 5'h08, 32'h0);
        checkOutput("Irq before edge flag", {31'd0, Irq}, 32'd0);
        step();
        readReg("EDGE_STAT at 3rd edge", 5'h08, 32'h81);
        checkOutput("Irq edge masked in", {31'd0, Irq}, 32'd1);
        applyStimulus(5'h08, 32'h0000_0001);
        readReg("EDGE_STAT after W1C", 5'h08, 32'h80);
        checkOutput("Irq after W1C", {31'd0, Irq}, 32'd0);

        // Timer compare-match.
        applyStimulus(5'h14, 32'd3);
        applyStimulus(5'h18, 32'h3);
        readReg("CNT after enable", 5'h10, 32'd0);
        step(); readReg("CNT 1", 5'h10, 32'd1);
        step(); readReg("CNT 2", 5'h10, 32'd2);
        step(); readReg("CNT 3", 5'h10, 32'd3);
        step(); readReg("CNT wrap to 0", 5'h10, 32'd0);
        readReg("MATCH set", 5'h1C, 32'd1);
        checkOutput("Irq on match", {31'd0, Irq}, 32'd1);
        step(); step(); step();
        readReg("CNT 3 again", 5'h10, 32'd3);
        applyStimulus(5'h1C, 32'd1);
        readReg("MATCH set beats clear", 5'h1C, 32'd1);
        readReg("CNT after 2nd match", 5'h10, 32'd0);
        applyStimulus(5'h1C, 32'd1);
        readReg("MATCH cleared", 5'h1C, 32'd0);
        checkOutput("Irq after match clear", {31'd0, Irq}, 32'd0);
        applyStimulus(5'h18, 32'h0);
        readReg("CNT frozen", 5'h10, 32'd2);
        step();
        readReg("CNT held with EN=0", 5'h10, 32'd2);

        // Counter wrap and CPU override.
        applyStimulus(5'h10, 32'hFFFF_FFFF);
        applyStimulus(5'h14, 32'd5);
        applyStimulus(5'h18, 32'h1);
        readReg("CNT max", 5'h10, 32'hFFFF_FFFF);
        step();
        readReg("CNT wrapped", 5'h10, 32'd0);
        readReg("no MATCH on wrap", 5'h1C, 32'd0);
        applyStimulus(5'h10, 32'h10);
        readReg("CNT override", 5'h10, 32'h10);
        step();
        readReg("CNT after override", 5'h10, 32'h11);

        // Misses: unaligned and outside the window.
        MemRead = 1'b1; MemWrite = 1'b1; WriteData = 32'hDEAD_BEEF;
        Address = BASE + 32'h2;
        #1;
        checkOutput("unaligned Hit", {31'd0, Hit}, 32'd0);
        checkOutput("unaligned ReadData", ReadData, 32'd0);
        step();
        Address = BASE + 32'h20;
        #1;
        checkOutput("outside Hit", {31'd0, Hit}, 32'd0);
        checkOutput("outside ReadData", ReadData, 32'd0);
        step();
        MemWrite = 1'b0;
        readReg("PORT_OUT untouched", 5'h00, 32'hA5A5_0F0F);
        readReg("CMP untouched", 5'h14, 32'd5);

        // Reset in the middle of counting with all edge flags pending.
        applyStimulus(5'h0C, 32'hFF);
        PortIn = 8'h00;
        step(); step(); step();
        PortIn = 8'hFF;
        step(); step(); step();
        readReg("EDGE_STAT all set", 5'h08, 32'hFF);
        checkOutput("Irq pending", {31'd0, Irq}, 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("async reset PortOut", PortOut, 32'd0);
        checkOutput("async reset Irq", {31'd0, Irq}, 32'd0);
        readReg("async reset EDGE_STAT", 5'h08, 32'd0);
        readReg("async reset CNT", 5'h10, 32'd0);
        PortIn = 8'h00;
        step(); step();
        reset = 1'b1;
        step(); step();
        readReg("CNT idle after reset", 5'h10, 32'd0);
        applyStimulus(5'h14, 32'd10);
        applyStimulus(5'h18, 32'h1);
        readReg("CNT at re-enable", 5'h10, 32'd0);
        step();
        readReg("CNT first increment", 5'h10, 32'd1);
        MemRead = 1'b0;
        step(); step();

        cmpOn = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
